// File: rtl/roc_cmd_host_if.sv
// Request, UART byte-stream and response signals of the RoC command host.
// The slave modport is the host itself; the master modport is the
// requester/UART side that drives requests and received bytes.
interface roc_cmd_host_if #(
  parameter int ROC_INPUTS  = 8,
  parameter int ROC_OUTPUTS = 8
);
  logic                   i_req_valid;
  logic                   o_req_ready;
  logic [1:0]             i_req_op;
  logic [ROC_INPUTS-1:0]  i_req_inputs;
  logic [31:0]            i_req_tps;
  logic                   i_req_en;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;
  logic [7:0]             i_rx_data;
  logic                   i_rx_valid;
  logic                   o_rsp_valid;
  logic                   o_rsp_timeout;
  logic [ROC_OUTPUTS-1:0] o_rsp_outputs;

  modport slave (
    input  i_req_valid, i_req_op, i_req_inputs, i_req_tps, i_req_en,
    input  i_tx_ready, i_rx_data, i_rx_valid,
    output o_req_ready, o_tx_data, o_tx_valid,
    output o_rsp_valid, o_rsp_timeout, o_rsp_outputs
  );

  modport master (
    output i_req_valid, i_req_op, i_req_inputs, i_req_tps, i_req_en,
    output i_tx_ready, i_rx_data, i_rx_valid,
    input  o_req_ready, o_tx_data, o_tx_valid,
    input  o_rsp_valid, o_rsp_timeout, o_rsp_outputs
  );
endinterface

// File: rtl/roc_cmd_host.sv
// RoC command host: serialises parallel requests into opcode+payload byte
// frames for a UART TX and collects output-readback bytes from a UART RX.
// One request is in flight at a time; every request ends with a one-cycle
// response pulse (DONE state), except when aborted by reset.
module roc_cmd_host #(
  parameter int ROC_INPUTS     = 8,
  parameter int ROC_OUTPUTS    = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  roc_cmd_host_if.slave   bus
);

  localparam int IN_BYTES  = (ROC_INPUTS + 7) >> 3;
  localparam int OUT_BYTES = (ROC_OUTPUTS + 7) >> 3;
  localparam int PAY_BYTES = (IN_BYTES > 4) ? IN_BYTES : 4;
  localparam int PAY_W     = 8 * PAY_BYTES;
  localparam int LEN_W     = $clog2(PAY_BYTES + 2);
  localparam int IDX_W     = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ASM_W     = 8 * OUT_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RSP,
    DONE
  } state_t;

  state_t                 state_q;
  logic [1:0]             op_q;
  logic [7:0]             tx_data_q;
  logic                   tx_valid_q;
  logic [PAY_W-1:0]       shift_q;
  logic [LEN_W-1:0]       len_q;
  logic [ASM_W-1:0]       asm_q;
  logic [IDX_W-1:0]       idx_q;
  logic [TO_W-1:0]        to_q;
  logic                   rsp_valid_q;
  logic                   rsp_timeout_q;
  logic [ROC_OUTPUTS-1:0] rsp_outputs_q;

  logic [PAY_W-1:0]       payload_d;
  logic [LEN_W-1:0]       len_d;
  logic [ASM_W-1:0]       asm_d;

  assign bus.o_req_ready   = (state_q == IDLE) & ~i_rst;
  assign bus.o_tx_data     = tx_data_q;
  assign bus.o_tx_valid    = tx_valid_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
  assign bus.o_rsp_outputs = rsp_outputs_q;

  // Payload bytes (after the opcode) and total frame length for the request.
  always_comb begin
    payload_d = '0;
    len_d     = LEN_W'(1);
    case (bus.i_req_op)
      2'd0: begin
        payload_d[ROC_INPUTS-1:0] = bus.i_req_inputs;
        len_d                     = LEN_W'(1 + IN_BYTES);
      end
      2'd1: begin
        payload_d[31:0] = bus.i_req_tps;
        len_d           = LEN_W'(5);
      end
      2'd2: begin
        payload_d[0] = bus.i_req_en;
        len_d        = LEN_W'(2);
      end
      default: ;
    endcase
  end

  // Assembly register with the incoming rx byte dropped into its slot.
  always_comb begin
    asm_d = asm_q;
    asm_d[{idx_q, 3'b000} +: 8] = bus.i_rx_data;
  end

  // Request FSM: frame transmission, response collection and timeout.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      op_q          <= 2'd0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      shift_q       <= '0;
      len_q         <= '0;
      asm_q         <= '0;
      idx_q         <= '0;
      to_q          <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_outputs_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.i_req_valid) begin
            op_q       <= bus.i_req_op;
            tx_data_q  <= {6'b0, bus.i_req_op} + 8'd1;
            tx_valid_q <= 1'b1;
            shift_q    <= payload_d;
            len_q      <= len_d;
            state_q    <= SEND;
          end
        end
        SEND: begin
          if (bus.i_tx_ready) begin
            tx_data_q <= shift_q[7:0];
            shift_q   <= shift_q >> 8;
            len_q     <= len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              tx_valid_q <= 1'b0;
              if (op_q == 2'd3) begin
                asm_q   <= '0;
                idx_q   <= '0;
                to_q    <= '0;
                state_q <= WAIT_RSP;
              end else begin
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b0;
                state_q       <= DONE;
              end
            end
          end
        end
        WAIT_RSP: begin
          if (bus.i_rx_valid) begin
            if (idx_q == IDX_W'(OUT_BYTES - 1)) begin
              rsp_outputs_q <= asm_d[ROC_OUTPUTS-1:0];
              rsp_valid_q   <= 1'b1;
              rsp_timeout_q <= 1'b0;
              state_q       <= DONE;
            end else begin
              asm_q <= asm_d;
              idx_q <= idx_q + IDX_W'(1);
              to_q  <= '0;
            end
          end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= DONE;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roc_cmd_host.sv
// Directed bench for roc_cmd_host (ROC_INPUTS=12, ROC_OUTPUTS=10,
// TIMEOUT_CYCLES=100). Expected tx bytes and responses are queued when a
// request is issued and popped by a negedge monitor as the DUT produces them.
module tb_roc_cmd_host;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hsCount = 0;
  int rspCount = 0;
  int lastHsCycle = 0;
  int rspCycle = 0;
  int acceptCycle = 0;
  int strobeCycle = 0;

  logic [7:0]  txQ[$];
  logic [31:0] rspQ[$];
  logic [9:0]  expOutputs = 10'h000;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData = 8'h00;

  roc_cmd_host_if #(.ROC_INPUTS(12), .ROC_OUTPUTS(10)) bus ();

  roc_cmd_host #(
    .ROC_INPUTS(12),
    .ROC_OUTPUTS(10),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure latencies.
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard tx bytes and responses, check stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("tx_stall_valid", 32'(bus.o_tx_valid), 32'd1);
        checkOutput("tx_stall_data", 32'(bus.o_tx_data), 32'(prevData));
      end
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        hsCount++;
        lastHsCycle = cyc;
        if (txQ.size() == 0) checkOutput("tx_unexpected", 32'(bus.o_tx_data), 32'h100);
        else checkOutput("tx_byte", 32'(bus.o_tx_data), 32'(txQ.pop_front()));
      end
      prevStall = bus.o_tx_valid && !bus.i_tx_ready;
      prevData  = bus.o_tx_data;
      if (bus.o_rsp_valid) begin
        rspCount++;
        rspCycle = cyc;
        checkOutput("rsp_req_ready_low", 32'(bus.o_req_ready), 32'd0);
        if (rspQ.size() == 0)
          checkOutput("rsp_unexpected", 32'({bus.o_rsp_timeout, bus.o_rsp_outputs}), 32'h800);
        else
          checkOutput("rsp_value", 32'({bus.o_rsp_timeout, bus.o_rsp_outputs}), rspQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] inp,
                               input logic [31:0] tps, input logic en);
    int n;
    txQ.push_back({6'b0, op} + 8'd1);
    case (op)
      2'd0: begin txQ.push_back(inp[7:0]); txQ.push_back({4'b0, inp[11:8]}); end
      2'd1: begin
        txQ.push_back(tps[7:0]);   txQ.push_back(tps[15:8]);
        txQ.push_back(tps[23:16]); txQ.push_back(tps[31:24]);
      end
      2'd2: txQ.push_back({7'b0, en});
      default: ;
    endcase
    if (op != 2'd3) rspQ.push_back(32'({1'b0, expOutputs}));
    @(posedge clk); #1;
    bus.i_req_valid  = 1'b1;
    bus.i_req_op     = op;
    bus.i_req_inputs = inp;
    bus.i_req_tps    = tps;
    bus.i_req_en     = en;
    n = 0;
    @(negedge clk);
    while (!bus.o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("req_ready", 32'(bus.o_req_ready), 32'd1);
    @(posedge clk); #1;
    acceptCycle = cyc;
    bus.i_req_valid = 1'b0;
  endtask

  task automatic waitHs(input int target);
    int n = 0;
    while (hsCount < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("hs_wait", 32'(hsCount), 32'(target));
  endtask

  task automatic waitRsp(input int target);
    int n = 0;
    while (rspCount < target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("rsp_wait", 32'(rspCount), 32'(target));
  endtask

  task automatic sendRx(input logic [7:0] data);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = data;
    strobeCycle    = cyc;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  // Directed stimulus sequence.
  initial begin
    int base;
    int rbase;
    int pat[4] = '{1, 0, 0, 1};
    int n;

    bus.i_req_valid = 1'b0; bus.i_req_op = 2'd0; bus.i_req_inputs = 12'h0;
    bus.i_req_tps = 32'h0; bus.i_req_en = 1'b0; bus.i_tx_ready = 1'b1;
    bus.i_rx_data = 8'h00; bus.i_rx_valid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
    checkOutput("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(bus.o_tx_data), 32'h00);
    checkOutput("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    checkOutput("rst_rsp_timeout", 32'(bus.o_rsp_timeout), 32'd0);
    checkOutput("rst_rsp_outputs", 32'(bus.o_rsp_outputs), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", 32'(bus.o_req_ready), 32'd1);

    // SET_INPUTS 0xABC, back-to-back
    $display("[TB] SET_INPUTS");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd0, 12'hABC, 32'h0, 1'b0);
    waitRsp(rbase + 1);
    checkOutput("inputs_hs_count", 32'(hsCount - base), 32'd3);
    checkOutput("inputs_back_to_back", 32'(lastHsCycle - acceptCycle), 32'd2);
    checkOutput("inputs_rsp_latency", 32'(rspCycle - lastHsCycle), 32'd1);

    // SET_TPS with tx_ready toggling 1,0,0,1
    $display("[TB] SET_TPS stalled");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd1, 12'h0, 32'h12345678, 1'b0);
    n = 0;
    while (rspCount < rbase + 1 && n < 100) begin
      bus.i_tx_ready = pat[n % 4] != 0;
      @(posedge clk); #1;
      n++;
    end
    bus.i_tx_ready = 1'b1;
    checkOutput("tps_rsp", 32'(rspCount), 32'(rbase + 1));
    checkOutput("tps_hs_count", 32'(hsCount - base), 32'd5);

    // READ_OUTPUTS -> 0x3FF
    $display("[TB] READ 0x3FF");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd3, 12'h0, 32'h0, 1'b0);
    expOutputs = 10'h3FF;
    rspQ.push_back(32'({1'b0, expOutputs}));
    waitHs(base + 1);
    sendRx(8'hFF);
    sendRx(8'h03);
    waitRsp(rbase + 1);
    checkOutput("read_rsp_latency", 32'(rspCycle - strobeCycle), 32'd1);

    // READ_OUTPUTS -> 0x212, upper bits of last byte discarded
    $display("[TB] READ 0x212");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd3, 12'h0, 32'h0, 1'b0);
    expOutputs = 10'h212;
    rspQ.push_back(32'({1'b0, expOutputs}));
    waitHs(base + 1);
    sendRx(8'h12);
    sendRx(8'hFE);
    waitRsp(rbase + 1);
    @(negedge clk);
    checkOutput("read_held", 32'(bus.o_rsp_outputs), 32'h212);

    // READ_OUTPUTS timeout after one byte
    $display("[TB] READ timeout");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd3, 12'h0, 32'h0, 1'b0);
    rspQ.push_back(32'({1'b1, expOutputs}));
    waitHs(base + 1);
    sendRx(8'h55);
    waitRsp(rbase + 1);
    checkOutput("timeout_latency", 32'(rspCycle - strobeCycle), 32'd101);
    @(negedge clk);
    checkOutput("timeout_outputs_kept", 32'(bus.o_rsp_outputs), 32'h212);

    // SET_TPS aborted by reset after the 2nd byte
    $display("[TB] SET_TPS aborted by reset");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd1, 12'h0, 32'hCAFEF00D, 1'b0);
    waitHs(base + 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    txQ.delete();
    rspQ.delete();
    expOutputs = 10'h000;
    @(negedge clk);
    checkOutput("abort_tx_valid", 32'(bus.o_tx_valid), 32'd0);
    checkOutput("abort_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    checkOutput("abort_outputs", 32'(bus.o_rsp_outputs), 32'h0);
    checkOutput("abort_ready", 32'(bus.o_req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("abort_hs_count", 32'(hsCount - base), 32'd2);
    checkOutput("abort_no_rsp", 32'(rspCount), 32'(rbase));

    // SET_EN(1) after abort
    $display("[TB] SET_EN");
    base = hsCount; rbase = rspCount;
    applyStimulus(2'd2, 12'h0, 32'h0, 1'b1);
    waitRsp(rbase + 1);
    checkOutput("en_hs_count", 32'(hsCount - base), 32'd2);

    // rx strobes in IDLE and SEND are ignored
    $display("[TB] stray rx strobes");
    base = hsCount; rbase = rspCount;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    bus.i_tx_ready = 1'b0;
    applyStimulus(2'd3, 12'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    checkOutput("stray_outputs", 32'(bus.o_rsp_outputs), 32'h0);
    checkOutput("stray_no_rsp", 32'(rspCount), 32'(rbase));
    checkOutput("stray_still_sending", 32'(bus.o_tx_valid), 32'd1);
    @(posedge clk); #1;
    bus.i_tx_ready = 1'b1;
    expOutputs = 10'h134;
    rspQ.push_back(32'({1'b0, expOutputs}));
    waitHs(base + 1);
    sendRx(8'h34);
    sendRx(8'h01);
    waitRsp(rbase + 1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("tx_queue_drained", 32'(txQ.size()), 32'd0);
    checkOutput("rsp_queue_drained", 32'(rspQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/roc_cmd_host.md
# roc_cmd_host

Hardware initiator for the RoC serial command protocol: the host-side counterpart of the command controller. It turns parallel requests (set inputs, set TPS, set enable, read outputs) into the byte frames the controller decodes. It then collects the controller's output-readback bytes into a parallel response. It sits between a byte-level UART TX/RX pair and a local requester, such as a self-test sequencer or a board-to-board bridge.

## Interface
- ROC_INPUTS, 8, RoC input width; IN_BYTES = (ROC_INPUTS+7)>>3
- ROC_OUTPUTS, 8, RoC output width; OUT_BYTES = (ROC_OUTPUTS+7)>>3
- TIMEOUT_CYCLES, 1000000, idle cycles allowed between response bytes; ≥ 1
- i_clk  in  1  single clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  `(state==IDLE) & ~i_rst`
- i_req_op  in  2  0=SET_INPUTS, 1=SET_TPS, 2=SET_EN, 3=READ_OUTPUTS
- i_req_inputs  in  ROC_INPUTS  payload for SET_INPUTS
- i_req_tps  in  32  payload for SET_TPS
- i_req_en  in  1  payload for SET_EN
- o_tx_data  out  8  byte to UART TX
- o_tx_valid  out  1  byte present
- i_tx_ready  in  1  UART TX accepts byte
- i_rx_data  in  8  byte from UART RX
- i_rx_valid  in  1  one-cycle strobe per received byte
- o_rsp_valid  out  1  one-cycle pulse, request complete
- o_rsp_timeout  out  1  qualifies o_rsp_valid; 1 = READ timed out
- o_rsp_outputs  out  ROC_OUTPUTS  last successfully read RoC outputs (held)

## Operation
- Frame formats: opcode byte = i_req_op+1 (0x01..0x04).
  - SET_INPUTS: opcode followed by IN_BYTES bytes, LSB first, pad bits 0.
  - SET_TPS: opcode followed by 4 bytes, little-endian.
  - SET_EN: opcode followed by 1 byte, {7'b0, en}.
  - READ_OUTPUTS: opcode only; controller answers with OUT_BYTES bytes, LSB first.
- FSM states: IDLE → SEND → (WAIT_RSP for READ) → IDLE.
- IDLE: on i_req_valid & o_req_ready, latch the whole frame into a byte shift register and load the byte counter with frame length (1, 2, 5 or 1+IN_BYTES). Go to SEND.
- SEND: o_tx_valid=1 and o_tx_data=current byte, both held stable until i_tx_ready. On handshake, shift and decrement. After the last byte:
  - Write ops: pulse o_rsp_valid with o_rsp_timeout=0, then return to IDLE.
  - READ: clear the assembly register and rx byte index, clear the timeout counter, go to WAIT_RSP.
- WAIT_RSP:
  - Each i_rx_valid writes i_rx_data into byte slot [index], increments the index and clears the timeout counter.
  - When the OUT_BYTES-th byte arrives, o_rsp_outputs takes the assembly bits [ROC_OUTPUTS-1:0]; bits above ROC_OUTPUTS are discarded. Pulse o_rsp_valid with timeout=0 and return to IDLE.
  - When the timeout counter reaches TIMEOUT_CYCLES-1 with no byte, pulse o_rsp_valid with o_rsp_timeout=1. o_rsp_outputs is not changed. Return to IDLE.
- i_rx_valid outside WAIT_RSP is ignored and has no side effects.
- Simultaneous events in WAIT_RSP: if the final byte and timeout expiry land in the same cycle, the byte wins (success).
- Only one request is in flight at a time. o_req_ready is 0 from acceptance until the cycle after the o_rsp_valid pulse.

## Timing
- Reset values: state IDLE, o_tx_valid 0, o_tx_data 0x00, o_rsp_valid 0, o_rsp_timeout 0, o_rsp_outputs 0, all counters 0. o_req_ready is 0 while i_rst=1 and 1 in the first cycle after.
- Request accepted at edge N → o_tx_valid=1 with opcode from N+1.
- With i_tx_ready held 1, a frame of L bytes transfers on cycles N+1..N+L, back-to-back with no gaps.
- Write ops: o_rsp_valid at cycle N+L+1; a new request can be accepted at N+L+2.
- READ: o_rsp_valid is asserted the cycle after the last rx strobe is sampled.
- Reset mid-frame:
  - o_tx_valid drops at the next edge and the partial frame is abandoned; no bytes are sent to finish it.
  - No o_rsp_valid is generated for the aborted request.
  - o_rsp_outputs returns to 0.
- Timeout counter width is clog2(TIMEOUT_CYCLES); it never wraps (saturates into the expiry action).

## Test plan
All scenarios use ROC_INPUTS=12, ROC_OUTPUTS=10, TIMEOUT_CYCLES=100.
- SET_INPUTS with i_req_inputs=0xABC, i_tx_ready=1 → bytes 0x01, 0xBC, 0x0A on consecutive cycles; o_rsp_valid=1, timeout=0 one cycle after the last byte.
- SET_TPS with tps=0x12345678, i_tx_ready toggling 1,0,0,1,… → bytes 0x02, 0x78, 0x56, 0x34, 0x12; o_tx_data stable across every stall cycle; exactly 5 handshakes.
- READ_OUTPUTS: tx 0x04, then rx 0xFF, 0x03 → o_rsp_outputs=0x3FF. Next READ with rx 0x12, 0xFE → 0x212 (upper 6 bits discarded).
- READ_OUTPUTS: rx 0x55, then silence → o_rsp_valid with o_rsp_timeout=1 exactly 100 cycles after the 0x55 strobe; o_rsp_outputs keeps its previous value.
- SET_TPS with i_tx_ready=1, i_rst asserted after the 2nd byte handshake → o_tx_valid=0 at the next edge and no rsp pulse. A following SET_EN(1) sends 0x03, 0x01.
- i_rx_valid strobes (0xAA) while in IDLE and SEND → no change to o_rsp_outputs, no o_rsp_valid. A subsequent READ assembles only post-opcode bytes.
